// File: rtl/blob_pkg.sv
// Shared constants and FSM state encoding for the BLOB line-buffer stage.
package blob_pkg;

   localparam int unsigned COLW  = 14;  // column address width
   localparam int unsigned ROWW  = 12;  // row counter width
   localparam int unsigned WIDTH = 8;   // pixel width

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StDrain = 2'd2
   } state_e;

endpackage

// File: rtl/blob_lbuf_ctrl_if.sv
// Bundle of the pixel input stream, the labeler output stream and both line-buffer RAM ports.
// The optional m_left signal exists only when BLOB_LBUF_LEFT_EN is defined.
interface blob_lbuf_ctrl_if
   import blob_pkg::*;
#(
   parameter int unsigned AW = COLW,
   parameter int unsigned DW = WIDTH,
   parameter int unsigned RW = ROWW
) ();

   // Pixel input stream
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] s_data;

   // Output stream towards the labeler
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_pix;
   logic [DW-1:0] m_above;
   logic [AW-1:0] m_col;
   logic [RW-1:0] m_row;
   logic          m_eol;
   logic          m_eof;
`ifdef BLOB_LBUF_LEFT_EN
   logic [DW-1:0] m_left;
`endif

   // Line-buffer RAM: port A writes, port B reads combinationally
   logic [AW-1:0] ram_addra;
   logic          ram_wea;
   logic [DW-1:0] ram_dina;
   logic [AW-1:0] ram_addrb;
   logic [DW-1:0] ram_doutb;

`ifdef BLOB_LBUF_LEFT_EN
   modport slave (
      input  s_valid, s_data, m_ready, ram_doutb,
      output s_ready, m_valid, m_pix, m_above, m_col, m_row, m_eol, m_eof, m_left,
             ram_addra, ram_wea, ram_dina, ram_addrb
   );
   modport master (
      output s_valid, s_data, m_ready, ram_doutb,
      input  s_ready, m_valid, m_pix, m_above, m_col, m_row, m_eol, m_eof, m_left,
             ram_addra, ram_wea, ram_dina, ram_addrb
   );
`else
   modport slave (
      input  s_valid, s_data, m_ready, ram_doutb,
      output s_ready, m_valid, m_pix, m_above, m_col, m_row, m_eol, m_eof,
             ram_addra, ram_wea, ram_dina, ram_addrb
   );
   modport master (
      output s_valid, s_data, m_ready, ram_doutb,
      input  s_ready, m_valid, m_pix, m_above, m_col, m_row, m_eol, m_eof,
             ram_addra, ram_wea, ram_dina, ram_addrb
   );
`endif

endinterface

// File: rtl/blob_lbuf_cnt.sv
// Column/row raster counter with end-of-line and end-of-frame flags.
// The counters stop at the last pixel of the frame; a new clear restarts them.
module blob_lbuf_cnt
   import blob_pkg::*;
#(
   parameter int unsigned AW = COLW,
   parameter int unsigned RW = ROWW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_i,
   input  logic          inc_i,
   input  logic [AW-1:0] width_i,
   input  logic [RW-1:0] height_i,
   output logic [AW-1:0] col_o,
   output logic [RW-1:0] row_o,
   output logic          eol_o,
   output logic          eof_o
);

   logic [AW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic          eol, eof;

   assign eol = (col_q == width_i - AW'(1));
   assign eof = eol && (row_q == height_i - RW'(1));

   // Next count: clear on frame start, advance/wrap on each accepted pixel
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (clr_i) begin
         col_d = '0;
         row_d = '0;
      end else if (inc_i && !eof) begin
         if (eol) begin
            col_d = '0;
            row_d = row_q + RW'(1);
         end else begin
            col_d = col_q + AW'(1);
         end
      end
   end

   // Counter state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_q <= '0;
         row_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end

   assign col_o = col_q;
   assign row_o = row_q;
   assign eol_o = eol;
   assign eof_o = eof;

endmodule

// File: rtl/blob_lbuf_ctrl.sv
// Line-buffer controller for the BLOB connected-component stage.
// Writes the current row into the external line buffer while reading the previous row at the
// same column, and presents pixel, above-neighbour and coordinates to the labeler.
// Optional feature macro: BLOB_LBUF_LEFT_EN adds the m_left (left-neighbour) output.
module blob_lbuf_ctrl
   import blob_pkg::*;
#(
   parameter int unsigned AW = COLW,
   parameter int unsigned DW = WIDTH,
   parameter int unsigned RW = ROWW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic [AW-1:0]     cfg_width_i,
   input  logic [RW-1:0]     cfg_height_i,
   output logic              busy_o,
   output logic              frame_done_o,
   blob_lbuf_ctrl_if.slave   bus_io
);

   state_e        state_q;
   logic [AW-1:0] width_q;
   logic [RW-1:0] height_q;
   logic          busy_q;
   logic          frame_done_q;
   logic          m_valid_q;
   logic [DW-1:0] m_pix_q;
   logic [DW-1:0] m_above_q;
   logic [AW-1:0] m_col_q;
   logic [RW-1:0] m_row_q;
   logic          m_eol_q;
   logic          m_eof_q;
`ifdef BLOB_LBUF_LEFT_EN
   logic [DW-1:0] m_left_q;
`endif

   logic          start_ok;
   logic          s_ready;
   logic          accept;
   logic [AW-1:0] cnt_col;
   logic [RW-1:0] cnt_row;
   logic          cnt_eol;
   logic          cnt_eof;

   assign start_ok = start_i && (state_q == StIdle) &&
                     (cfg_width_i != '0) && (cfg_height_i != '0);
   // No skid buffer: a new pixel may only enter when the output register is free or draining
   assign s_ready  = (state_q == StRun) && (!m_valid_q || bus_io.m_ready);
   assign accept   = bus_io.s_valid && s_ready;

   blob_lbuf_cnt #(
      .AW (AW),
      .RW (RW)
   ) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (start_ok),
      .inc_i    (accept),
      .width_i  (width_q),
      .height_i (height_q),
      .col_o    (cnt_col),
      .row_o    (cnt_row),
      .eol_o    (cnt_eol),
      .eof_o    (cnt_eof)
   );

   // Frame sequencing FSM together with the registered output beat
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         width_q      <= '0;
         height_q     <= '0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         m_valid_q    <= 1'b0;
         m_pix_q      <= '0;
         m_above_q    <= '0;
         m_col_q      <= '0;
         m_row_q      <= '0;
         m_eol_q      <= 1'b0;
         m_eof_q      <= 1'b0;
`ifdef BLOB_LBUF_LEFT_EN
         m_left_q     <= '0;
`endif
      end else begin
         frame_done_q <= 1'b0;

         if (accept) begin
            m_valid_q <= 1'b1;
            m_pix_q   <= bus_io.s_data;
            // Row 0 has no valid previous row; this also masks stale RAM after a reset
            m_above_q <= (cnt_row == '0) ? '0 : bus_io.ram_doutb;
            m_col_q   <= cnt_col;
            m_row_q   <= cnt_row;
            m_eol_q   <= cnt_eol;
            m_eof_q   <= cnt_eof;
`ifdef BLOB_LBUF_LEFT_EN
            // m_pix_q still holds the previously accepted pixel at this edge
            m_left_q  <= (cnt_col == '0) ? '0 : m_pix_q;
`endif
         end else if (bus_io.m_ready) begin
            m_valid_q <= 1'b0;
         end

         unique case (state_q)
            StIdle: begin
               if (start_ok) begin
                  width_q  <= cfg_width_i;
                  height_q <= cfg_height_i;
                  busy_q   <= 1'b1;
                  state_q  <= StRun;
               end
            end
            StRun: begin
               if (accept && cnt_eof) begin
                  state_q <= StDrain;
               end
            end
            StDrain: begin
               if (m_valid_q && bus_io.m_ready) begin
                  state_q      <= StIdle;
                  busy_q       <= 1'b0;
                  frame_done_q <= 1'b1;
               end
            end
            default: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy_o         = busy_q;
   assign frame_done_o   = frame_done_q;

   assign bus_io.s_ready = s_ready;
   assign bus_io.m_valid = m_valid_q;
   assign bus_io.m_pix   = m_pix_q;
   assign bus_io.m_above = m_above_q;
   assign bus_io.m_col   = m_col_q;
   assign bus_io.m_row   = m_row_q;
   assign bus_io.m_eol   = m_eol_q;
   assign bus_io.m_eof   = m_eof_q;
`ifdef BLOB_LBUF_LEFT_EN
   assign bus_io.m_left  = m_left_q;
`endif

   // Write the current pixel and read the previous row at the same column
   assign bus_io.ram_wea   = accept;
   assign bus_io.ram_addra = cnt_col;
   assign bus_io.ram_dina  = accept ? bus_io.s_data : '0;
   assign bus_io.ram_addrb = cnt_col;

endmodule

// File: tb/tb_blob_lbuf_ctrl.sv
// Scoreboard bench for blob_lbuf_ctrl with a behavioural line-buffer RAM model.
// Honours BLOB_LBUF_LEFT_EN for the m_left checks.
module tb_blob_lbuf_ctrl;
   import blob_pkg::*;

   localparam int AW = COLW;
   localparam int DW = WIDTH;
   localparam int RW = ROWW;

   typedef logic [DW-1:0] pix_q_t[$];

   typedef struct packed {
      logic [DW-1:0] pix;
      logic [DW-1:0] above;
      logic [DW-1:0] left;
      logic [AW-1:0] col;
      logic [RW-1:0] row;
      logic          eol;
      logic          eof;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] cfg_width;
   logic [RW-1:0] cfg_height;
   logic          busy;
   logic          frame_done;

   blob_lbuf_ctrl_if #(.AW(AW), .DW(DW), .RW(RW)) bus ();

   blob_lbuf_ctrl #(
      .AW (AW),
      .DW (DW),
      .RW (RW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start),
      .cfg_width_i  (cfg_width),
      .cfg_height_i (cfg_height),
      .busy_o       (busy),
      .frame_done_o (frame_done),
      .bus_io       (bus)
   );

   always #5 clk = ~clk;

   // Line-buffer RAM: synchronous write, combinational read
   logic [DW-1:0] mem [2**AW];
   always @(posedge clk) begin
      if (bus.ram_wea) mem[bus.ram_addra] <= bus.ram_dina;
   end
   assign bus.ram_doutb = mem[bus.ram_addrb];

   int    tests = 0;
   int    fails = 0;
   int    beats = 0;
   int    frames_done = 0;
   int    rdy_mode = 0;  // 0: ready high, 1: random, 2: held low
   beat_t exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic beat_t cur_beat();
      beat_t b;
      b.pix   = bus.m_pix;
      b.above = bus.m_above;
`ifdef BLOB_LBUF_LEFT_EN
      b.left  = bus.m_left;
`else
      b.left  = '0;
`endif
      b.col   = bus.m_col;
      b.row   = bus.m_row;
      b.eol   = bus.m_eol;
      b.eof   = bus.m_eof;
      return b;
   endfunction

   // Output-ready driver
   initial begin
      bus.m_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       bus.m_ready = 1'b1;
            1:       bus.m_ready = ($urandom_range(3) != 0);
            default: bus.m_ready = 1'b0;
         endcase
      end
   end

   // Monitor: pops expectations on every taken beat, checks hold and frame_done timing
   initial begin
      beat_t e, a, snap;
      logic  prev_stall;
      logic  done_pending;
      prev_stall   = 1'b0;
      done_pending = 1'b0;
      snap         = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_stall   = 1'b0;
            done_pending = 1'b0;
         end else begin
            if (done_pending) begin
               check("frame_done_pulse", 64'(frame_done), 64'd1);
               done_pending = 1'b0;
               frames_done++;
            end else if (frame_done) begin
               check("frame_done_spurious", 64'(frame_done), 64'd0);
            end
            a = cur_beat();
            if (prev_stall) begin
               check("hold_m_valid", 64'(bus.m_valid), 64'd1);
               check("hold_m_outputs", 64'(a), 64'(snap));
            end
            if (bus.m_valid && !bus.m_ready) begin
               check("stall_s_ready", 64'(bus.s_ready), 64'd0);
               check("stall_ram_wea", 64'(bus.ram_wea), 64'd0);
            end
            if (bus.m_valid && bus.m_ready) begin
               beats++;
               if (exp_q.size() == 0) begin
                  check("unexpected_beat", 64'(a.pix), 64'hdead);
               end else begin
                  e = exp_q.pop_front();
                  check("m_pix", 64'(a.pix), 64'(e.pix));
                  check("m_above", 64'(a.above), 64'(e.above));
                  check("m_col", 64'(a.col), 64'(e.col));
                  check("m_row", 64'(a.row), 64'(e.row));
                  check("m_eol", 64'(a.eol), 64'(e.eol));
                  check("m_eof", 64'(a.eof), 64'(e.eof));
`ifdef BLOB_LBUF_LEFT_EN
                  check("m_left", 64'(a.left), 64'(e.left));
`endif
               end
               if (a.eof) done_pending = 1'b1;
            end
            prev_stall = bus.m_valid && !bus.m_ready;
            snap       = a;
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: raster order, above = same column one row up, left = previous column
   task automatic push_frame(input int w, input int h, input pix_q_t pix);
      beat_t b;
      for (int r = 0; r < h; r++) begin
         for (int c = 0; c < w; c++) begin
            int idx = r * w + c;
            b.pix   = pix[idx];
            b.above = (r == 0) ? '0 : pix[idx - w];
            b.left  = (c == 0) ? '0 : pix[idx - 1];
            b.col   = AW'(c);
            b.row   = RW'(r);
            b.eol   = (c == w - 1);
            b.eof   = (idx == w * h - 1);
            exp_q.push_back(b);
         end
      end
   endtask

   task automatic do_start(input int w, input int h);
      start      = 1'b1;
      cfg_width  = AW'(w);
      cfg_height = RW'(h);
      step();
      start      = 1'b0;
   endtask

   task automatic send_pixels(input pix_q_t pix, input int max_gap);
      logic acc;
      int   n;
      foreach (pix[i]) begin
         if (max_gap > 0) begin
            repeat ($urandom_range(max_gap)) begin
               bus.s_valid = 1'b0;
               step();
            end
         end
         bus.s_valid = 1'b1;
         bus.s_data  = pix[i];
         n   = 0;
         acc = 1'b0;
         while (!acc && n < 300) begin
            @(negedge clk);
            acc = bus.s_ready;
            step();
            n++;
         end
         if (!acc) begin
            check("send_timeout", 64'd0, 64'd1);
            break;
         end
      end
      bus.s_valid = 1'b0;
   endtask

   task automatic wait_done(input int target);
      int n = 0;
      while (frames_done < target && n < 2000) begin
         step();
         n++;
      end
      check("frame_complete", 64'(frames_done >= target), 64'd1);
      check("busy_after_frame", 64'(busy), 64'd0);
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic run_frame(input int w, input int h, input pix_q_t pix, input int max_gap);
      int target = frames_done + 1;
      push_frame(w, h, pix);
      do_start(w, h);
      send_pixels(pix, max_gap);
      wait_done(target);
   endtask

   task automatic check_reset_values();
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_frame_done", 64'(frame_done), 64'd0);
      check("rst_m_valid", 64'(bus.m_valid), 64'd0);
      check("rst_m_eol", 64'(bus.m_eol), 64'd0);
      check("rst_m_eof", 64'(bus.m_eof), 64'd0);
      check("rst_ram_wea", 64'(bus.ram_wea), 64'd0);
      check("rst_s_ready", 64'(bus.s_ready), 64'd0);
      check("rst_m_pix", 64'(bus.m_pix), 64'd0);
      check("rst_m_above", 64'(bus.m_above), 64'd0);
      check("rst_m_col", 64'(bus.m_col), 64'd0);
      check("rst_m_row", 64'(bus.m_row), 64'd0);
      check("rst_ram_addra", 64'(bus.ram_addra), 64'd0);
      check("rst_ram_dina", 64'(bus.ram_dina), 64'd0);
`ifdef BLOB_LBUF_LEFT_EN
      check("rst_m_left", 64'(bus.m_left), 64'd0);
`endif
   endtask

   initial begin
      pix_q_t p;
      int     w, h, target;
      rst         = 1'b1;
      start       = 1'b0;
      cfg_width   = '0;
      cfg_height  = '0;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_values();
      rst = 1'b0;
      step();

      // Small frame 4x3, pixels 1..12
      p = {};
      for (int i = 1; i <= 12; i++) p.push_back(DW'(i));
      run_frame(4, 3, p, 0);

      // Row boundary: single-column frame
      p = '{8'd9, 8'd8, 8'd7, 8'd6};
      run_frame(1, 4, p, 0);

      // Output backpressure mid-row
      p = {};
      for (int i = 0; i < 12; i++) p.push_back(DW'($urandom));
      target = frames_done + 1;
      push_frame(6, 2, p);
      do_start(6, 2);
      fork
         send_pixels(p, 0);
         begin
            int n = 0;
            int goal = beats + 3;
            while (beats < goal && n < 100) begin
               step();
               n++;
            end
            rdy_mode = 2;
            repeat (5) step();
            rdy_mode = 0;
         end
      join
      wait_done(target);

      // Ignored starts with zero configuration
      do_start(0, 3);
      step();
      check("zero_w_busy", 64'(busy), 64'd0);
      check("zero_w_s_ready", 64'(bus.s_ready), 64'd0);
      do_start(4, 0);
      step();
      check("zero_h_busy", 64'(busy), 64'd0);

      // Start during RUN must not alter the frame size
      p = {};
      for (int i = 0; i < 6; i++) p.push_back(DW'(8'h40 + i));
      target = frames_done + 1;
      push_frame(3, 2, p);
      do_start(3, 2);
      fork
         send_pixels(p, 0);
         begin
            step();
            step();
            start      = 1'b1;
            cfg_width  = AW'(5);
            cfg_height = RW'(5);
            step();
            start      = 1'b0;
         end
      join
      wait_done(target);

      // Randomised frames with random gaps and random backpressure
      rdy_mode = 1;
      for (int k = 0; k < 6; k++) begin
         w = $urandom_range(7, 1);
         h = $urandom_range(4, 1);
         p = {};
         for (int i = 0; i < w * h; i++) p.push_back(DW'($urandom));
         run_frame(w, h, p, 2);
      end
      rdy_mode = 0;
      step();

      // Reset mid-frame after 6 of 12 pixels
      p = {};
      for (int i = 0; i < 12; i++) p.push_back(DW'(8'h80 + i));
      push_frame(4, 3, p);
      do_start(4, 3);
      p = p[0:5];
      send_pixels(p, 0);
      rst = 1'b1;
      @(negedge clk);
      check_reset_values();
      exp_q.delete();
      step();
      rst = 1'b0;
      step();
      @(negedge clk);
      check_reset_values();
      step();
      p = {};
      for (int i = 0; i < 12; i++) p.push_back(DW'(8'hc0 + i));
      run_frame(4, 3, p, 0);

      // Left-neighbour frame, width 3
      p = '{8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10};
      run_frame(3, 2, p, 0);

      repeat (3) step();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
